uart_host_bridge: RTL

UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

---
 rtl/uart_host_bridge.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - bridges byte streams to a polled single-cycle UART register bus
module uart_host_bridge #(
    parameter logic [3:0]  OFF_DATA  = 4'h0,
    parameter logic [3:0]  OFF_LSR   = 4'h1,
    parameter logic [3:0]  OFF_DIVR  = 4'h2,
    parameter logic [3:0]  OFF_DIVT  = 4'h3,
    parameter logic [3:0]  OFF_ACK   = 4'hF,
    parameter logic [15:0] DIVR_INIT = 16'd5208,
    parameter logic [15:0] DIVT_INIT = 16'd5208,
    parameter int unsigned GUARD     = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [3:0]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready
);

    typedef enum logic [2:0] {
        INIT_R,
        INIT_T,
        POLL,
        RX_RD,
        RX_CLR,
        TX_WR,
        TX_GUARD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  guard_q, guard_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  add_q, add_d;
    logic [31:0] dat_q, dat_d;
    logic        tx_ready_q, tx_ready_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;

    // Only the rs/ts status bits and the received byte are meaningful.
    logic dat_i_unused;
    assign dat_i_unused = ^DAT_I[31:8];

    // Next state plus the bus values that state presents, so every output is a flop.
    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !rx_ready;

        case (state_q)
            // Reset leaves INIT_R with an idle bus; the first edge presents the
            // divisor write and the following edge completes it.
            INIT_R:   state_d = stb_q ? INIT_T : INIT_R;
            INIT_T:   state_d = POLL;
            POLL: begin
                // Receive wins so the UART receiver is drained before it overruns.
                if (DAT_I[0] && !rx_valid_q) begin
                    state_d = RX_RD;
                end else if (DAT_I[5] && tx_valid) begin
                    state_d = TX_WR;
                end
            end
            RX_RD: begin
                rx_data_d  = DAT_I[7:0];
                rx_valid_d = 1'b1;
                state_d    = RX_CLR;
            end
            RX_CLR:   state_d = POLL;
            TX_WR: begin
                guard_d = 4'(GUARD - 1);
                state_d = TX_GUARD;
            end
            TX_GUARD: begin
                // Idle long enough for the UART's registered ts to drop.
                if (guard_q == 4'd0) begin
                    state_d = POLL;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default:  state_d = INIT_R;
        endcase

        stb_d      = 1'b0;
        we_d       = 1'b0;
        add_d      = 4'h0;
        dat_d      = 32'h0;
        tx_ready_d = 1'b0;
        case (state_d)
            INIT_R: begin
                stb_d = 1'b1;
                we_d  = 1'b1;
                add_d = OFF_DIVR;
                dat_d = {16'h0, DIVR_INIT};
            end
            INIT_T: begin
                stb_d = 1'b1;
                we_d  = 1'b1;
                add_d = OFF_DIVT;
                dat_d = {16'h0, DIVT_INIT};
            end
            POLL: begin
                stb_d = 1'b1;
                add_d = OFF_LSR;
            end
            RX_RD: begin
                stb_d = 1'b1;
                add_d = OFF_DATA;
            end
            RX_CLR: begin
                stb_d = 1'b1;
                we_d  = 1'b1;
                add_d = OFF_ACK;
            end
            TX_WR: begin
                stb_d      = 1'b1;
                we_d       = 1'b1;
                add_d      = OFF_DATA;
                dat_d      = {24'h0, tx_data};
                tx_ready_d = 1'b1;
            end
            default: begin
                stb_d = 1'b0;
            end
        endcase
    end

    // State, guard counter and every output register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= INIT_R;
            guard_q    <= 4'd0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            add_q      <= 4'h0;
            dat_q      <= 32'h0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= 8'h0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            add_q      <= add_d;
            dat_q      <= dat_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign STB_O    = stb_q;
    assign WE_O     = we_q;
    assign ADD_O    = add_q;
    assign DAT_O    = dat_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
